// File: rtl/fifo_pkg.sv
// Shared definitions for the 16 x 8 synchronous FIFO and the blocks around it.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;

  // Write-arbiter FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundles the producer handshake, the FIFO write port and the arbiter status.
// Latency: n/a (wiring only).
// Backpressure: req_ready_o per producer, driven from fifo_full_i by the arbiter.
//
// master : the arbiter (drives ready, FIFO write strobe/data and status)
// slave  : the environment (producers and the FIFO)
interface fifo_wr_arbiter_if
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = FIFO_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      fifo_full_i;
  logic                      fifo_wr_en_o;
  logic [DATA_W-1:0]         fifo_wdata_o;
  logic [NUM_REQ-1:0]        grant_o;
  logic                      busy_o;
  logic [15:0]               wr_count_o;

  modport master (
    input  req_valid_i, req_data_i, fifo_full_i,
    output req_ready_o, fifo_wr_en_o, fifo_wdata_o, grant_o, busy_o, wr_count_o
  );

  modport slave (
    output req_valid_i, req_data_i, fifo_full_i,
    input  req_ready_o, fifo_wr_en_o, fifo_wdata_o, grant_o, busy_o, wr_count_o
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: rotate priority to start just after 'last', take first set req.
// Latency: purely combinational.
// Backpressure: none; onehot is all zeros when no req bit is set.
//
// req    : request vector
// last   : index of the previous winner
// onehot : winner as a one-hot vector
// index  : winner as a binary index (0 when nothing requests)
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] index
);

  logic found;
  int   cand;

  // Walk offsets 1..N from last; offset N wraps back to last itself so a
  // lone requester that just finished still gets picked.
  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last) + i) % N;
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        index        = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers in bursts.
// Latency: grant registered one cycle after valid in IDLE; write path combinational from grant.
// Backpressure: fifo_full_i drops the granted producer's ready; the grant is held while full.
//
// clk_i, rst_i : clock, synchronous active-high reset
// bus          : producer valid/data/ready, FIFO full/wr_en/wdata, grant/busy/wr_count
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fifo_wr_arbiter_if.master bus
);

  localparam int         IDX_W      = $clog2(NUM_REQ);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [3:0]           beat_q, beat_d;
  logic [15:0]          wr_count_q, wr_count_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   ready;
  logic [DATA_W-1:0]    wdata;
  logic                 hs;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (bus.req_valid_i),
    .last   (last_q),
    .onehot (pick_onehot),
    .index  (pick_idx)
  );

  // Write path. Gated by rst_i so the cycle in which reset is applied never
  // issues a write, even if a burst was in flight.
  always_comb begin
    ready = '0;
    wdata = '0;
    hs    = 1'b0;
    if (state_q == BURST && !rst_i) begin
      hs            = bus.req_valid_i[gidx_q] & ~bus.fifo_full_i;
      ready[gidx_q] = hs;
      if (hs) begin
        wdata = bus.req_data_i[int'(gidx_q) * DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic. Full alone never releases the grant; only the burst
  // limit or the owner dropping valid does.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    beat_d     = beat_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid_i) begin
          state_d = BURST;
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (hs) begin
          beat_d     = beat_q + 4'd1;
          wr_count_d = wr_count_q + 16'd1;
        end
        if ((hs && beat_q == BURST_LAST) || !bus.req_valid_i[gidx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);  // producer 0 wins first
      beat_q     <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.req_ready_o  = ready;
  assign bus.fifo_wr_en_o = hs;
  assign bus.fifo_wdata_o = wdata;
  assign bus.grant_o      = grant_q;
  assign bus.busy_o       = (state_q == BURST);
  assign bus.wr_count_o   = wr_count_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the 16-entry × 8-bit synchronous FIFO among `NUM_REQ` producers. It grants one producer at a time for bursts of up to `MAX_BURST` beats. It never drives a write into a full FIFO, so the FIFO's `error_o` must stay low for write-side causes. It sits between the producer blocks and the FIFO's `wr_en_i`/`wdata_i`/`full_o` pins.

## Interface
- `NUM_REQ`, default 4: number of producers, 2..8.
- `DATA_W`, default 8: beat width; must match the FIFO width.
- `MAX_BURST`, default 4: maximum beats per grant, 1..15.
- `clk_i` (in, 1): single clock; everything is sampled on the rising edge.
- `rst_i` (in, 1): reset, synchronous and active-high.
- `req_valid_i` (in, `NUM_REQ`): producer n has a beat available.
- `req_data_i` (in, `NUM_REQ*DATA_W`): producer n's data occupies bits [n*DATA_W +: DATA_W].
- `req_ready_o` (out, `NUM_REQ`): beat from producer n is accepted this cycle.
- `fifo_full_i` (in, 1): the FIFO's `full_o`.
- `fifo_wr_en_o` (out, 1): drives the FIFO's `wr_en_i`.
- `fifo_wdata_o` (out, `DATA_W`): drives the FIFO's `wdata_i`.
- `grant_o` (out, `NUM_REQ`): registered one-hot current grant; all zeros when idle.
- `busy_o` (out, 1): FSM is in BURST.
- `wr_count_o` (out, 16): total accepted beats; wraps at 16 bits.

## Operation
- **FSM states:** IDLE, BURST.
- **IDLE:**
  - If any `req_valid_i` bit is set, pick the winner by rotating priority starting at `last_q+1` (mod `NUM_REQ`).
  - Register the one-hot winner into `grant_o`, clear `beat_cnt`, go to BURST.
  - Otherwise stay in IDLE.
- **BURST, with g the granted index:**
  - `req_ready_o[g] = req_valid_i[g] & ~fifo_full_i`; all other ready bits are 0.
  - `fifo_wr_en_o = req_ready_o[g]`.
  - `fifo_wdata_o` = slice g of `req_data_i`.
  - A handshake increments `beat_cnt` and `wr_count_o`.
- **Leaving BURST:** release to IDLE at the clock edge when either condition holds:
  - a handshake occurs with `beat_cnt == MAX_BURST-1`, or
  - `req_valid_i[g]` is 0 in that cycle.
  - On release: `last_q <= g`, `grant_o <= 0`.
- **FIFO full during BURST:** hold the grant with no write and no beat counted. The grant is not released by full alone.
- **IDLE outputs:** `fifo_wr_en_o = 0`; `fifo_wdata_o` = 0 whenever `fifo_wr_en_o` is 0.
- **Producer rule:** a producer must hold `req_valid_i` and its data stable until ready. The block does not check this.
- **Width rules:**
  - `beat_cnt` is 4 bits.
  - `wr_count_o` is 16 bits and wraps silently from 0xFFFF to 0.
  - `last_q` is $clog2(`NUM_REQ`) bits.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; `last_q = NUM_REQ-1`, so producer 0 wins first.
- **Reset mid-burst:** at the reset edge, outputs drop to their reset values and no write is issued in the reset cycle. Beats already in the FIFO are the FIFO's concern, since the FIFO resets on the same `rst_i`.
- **Grant latency:** `req_valid_i` rises in IDLE in cycle t; `grant_o` is set in t+1; the first write happens in t+1 if the FIFO is not full.
- **Arbitration bubble:** one IDLE cycle between consecutive grants. Peak throughput is `MAX_BURST/(MAX_BURST+1)` beats per cycle.
- **Write path:** ready, `fifo_wr_en_o` and `fifo_wdata_o` are combinational from the registered grant, `req_valid_i` and `fifo_full_i`. The FIFO's full flag is decoded from its registered pointers, so there is no combinational loop.
- **Filling the last slot:** a write that takes the FIFO to full in cycle t is followed by `fifo_full_i = 1` in t+1, which blocks the next write.
- **Simultaneous requests:** exactly one winner; the others wait for their turn in rotation.
- **Fairness bound:** a continuously valid producer is granted within `NUM_REQ-1` grants of other producers.

## Structure
- Shared package `fifo_pkg` holds `FIFO_DATA_W=8`, `FIFO_DEPTH=16` and the FSM state enum (IDLE=0, BURST=1). The arbiter's `DATA_W` defaults to `FIFO_DATA_W`.
- Sub-module `rr_pick` is a pure combinational rotate-and-priority-encode, with inputs req and last and outputs onehot and index. It is reused by the planned read-side scheduler.
- Expected RTL size is about 180 lines total.

## Test plan
- **Reset values:** hold `rst_i` for 2 cycles with `req_valid_i=4'b1111`. Expect `grant_o=0`, `fifo_wr_en_o=0` and `wr_count_o=0` throughout. After release, `grant_o=4'b0001` one cycle later.
- **Single-producer bursts:** producer 2 is valid continuously with data 0x20..0x29 and `MAX_BURST=4`.
  - Writes: 0x20–0x23, bubble, 0x24–0x27, bubble, 0x28–0x29.
  - FIFO read-back gives the same order; `wr_count_o=10`.
- **Round-robin alternation:** producers 0 and 3 are both valid continuously. Grants alternate 0,3,0,3 in bursts of 4, with never two consecutive grants to the same producer.
- **FIFO full, no error:** producer 1 streams 20 beats with no reads.
  - After 16 writes, `fifo_full_i=1`, `req_ready_o=0`, and FIFO `error_o` stays 0.
  - One read reopens the FIFO for exactly one further write.
- **Valid drop mid-burst:** producer 0 sends 2 beats, then deasserts valid while producer 1 is valid. The grant releases after beat 2 and `grant_o=4'b0010` two cycles later.
- **Reset mid-burst:** assert `rst_i` during beat 3 of a burst. No write occurs in the reset cycle, all outputs return to 0, and the next grant goes to producer 0.
